// File: rtl/rip_load_store_unit.sv
// rip_load_store_unit
//
// Load/store unit between the execute stage and data channel 1 of the
// memory management unit. Each accepted RV32I load/store becomes a single
// word-aligned memory request: byte strobes plus lane-replicated store data.
// The request is held across the memory unit's busy window. The unit then
// returns a one-cycle response: sign/zero-extended load data, or a store
// completion.
//
// Optional feature macro: RIP_LSU_MISALIGN_CHECK_EN
//   defined   - misaligned half/word accesses trap without touching memory
//               (cause 4 = load, 6 = store).
//   undefined - no trap is possible; halves use addr[1] only and words
//               ignore addr[1:0].
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_we            1 = store, 0 = load
//   req_funct3        RV32I width/sign code
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   resp_valid        one-cycle completion pulse, no backpressure
//   resp_rdata        extended load data (0 for stores/exceptions)
//   resp_exc          exception flag, valid with resp_valid
//   resp_cause        4 = load misaligned, 6 = store misaligned
//   mem_we, mem_re    single-cycle strobes to channel 1 we_1 / re_1
//   mem_addr, mem_din word-aligned address and replicated store data
//   mem_dout          read data from dout_1
//   mem_busy          busy_1 from the memory unit
module rip_load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_exc,
    output logic [3:0]            resp_cause,
    output logic [3:0]            mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic                  mem_busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

    state_e                state_q, state_d;
    logic                  first_wait_q, first_wait_d;
    logic                  is_store_q, is_store_d;
    logic                  unsigned_q, unsigned_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            off_q, off_d;
    logic [3:0]            strb_q, strb_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  exc_q, exc_d;
    logic [3:0]            cause_q, cause_d;

    // Request-side decode
    logic [1:0]            req_size;
    logic [1:0]            req_off;
    logic                  req_misaligned;
    logic [3:0]            req_strb;
    logic [DATA_WIDTH-1:0] req_din;
    logic                  accept;

    assign req_size  = req_funct3[1:0];
    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;

`ifdef RIP_LSU_MISALIGN_CHECK_EN
    assign req_misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                            (req_size[1] && (req_addr[1:0] != 2'b00)) ||
                            ((req_size == 2'b11) && (req_addr[1:0] != 2'b00));
    assign req_off        = req_addr[1:0];
`else
    // Without trapping, halves snap to the nearest halfword and words to the
    // word, so a misaligned address can never produce a strobe past lane 3.
    assign req_misaligned = 1'b0;
    assign req_off        = (req_size == 2'b00) ? req_addr[1:0] :
                            (req_size == 2'b01) ? {req_addr[1], 1'b0} : 2'b00;
`endif

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default before
        // the case so no path leaves it unassigned (which would infer a latch).
        req_strb = 4'b1111;
        req_din  = req_wdata;
        case (req_size)
            2'b00: begin
                req_strb = 4'b0001 << req_off;
                req_din  = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_strb = 4'b0011 << req_off;
                req_din  = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction from the returned word
    logic [DATA_WIDTH-1:0] load_sh;
    logic [DATA_WIDTH-1:0] load_data;

    assign load_sh = mem_dout >> {off_q, 3'b000};

    always_comb begin
        load_data = load_sh;
        case (size_q)
            2'b00:   load_data = {{24{~unsigned_q & load_sh[7]}}, load_sh[7:0]};
            2'b01:   load_data = {{16{~unsigned_q & load_sh[15]}}, load_sh[15:0]};
            default: ;
        endcase
    end

    // Next-state and strobe logic
    always_comb begin
        state_d      = state_q;
        first_wait_d = first_wait_q;
        is_store_d   = is_store_q;
        unsigned_d   = unsigned_q;
        size_d       = size_q;
        off_d        = off_q;
        strb_d       = strb_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        exc_d        = exc_q;
        cause_d      = cause_q;
        mem_we       = 4'b0000;
        mem_re       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_misaligned) begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        exc_d        = 1'b1;
                        cause_d      = req_we ? 4'd6 : 4'd4;
                    end else begin
                        is_store_d = req_we;
                        unsigned_d = req_funct3[2];
                        size_d     = req_size;
                        off_d      = req_off;
                        strb_d     = req_strb;
                        mem_addr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_din_d  = req_din;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // Strobes are live for exactly this one cycle so the memory
                // unit never sees the same request twice.
                if (!mem_busy) begin
                    mem_re       = ~is_store_q;
                    mem_we       = is_store_q ? strb_q : 4'b0000;
                    first_wait_d = 1'b1;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                // Busy rises only one cycle after the request, so the first
                // WAIT cycle's busy value is not meaningful.
                first_wait_d = 1'b0;
                if (!first_wait_q && !mem_busy) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = is_store_q ? '0 : load_data;
                    exc_d        = 1'b0;
                    cause_d      = 4'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= S_IDLE;
            first_wait_q <= 1'b0;
            is_store_q   <= 1'b0;
            unsigned_q   <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            strb_q       <= 4'b0000;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            exc_q        <= 1'b0;
            cause_q      <= 4'd0;
        end else begin
            state_q      <= state_d;
            first_wait_q <= first_wait_d;
            is_store_q   <= is_store_d;
            unsigned_q   <= unsigned_d;
            size_q       <= size_d;
            off_q        <= off_d;
            strb_q       <= strb_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            exc_q        <= exc_d;
            cause_q      <= cause_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_exc   = exc_q;
    assign resp_cause = cause_q;

endmodule

// File: tb/tb_rip_load_store_unit.sv
`timescale 1ns/1ps
module tb_rip_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_exc;
    logic [3:0]  resp_cause;
    logic [3:0]  mem_we;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_busy;

    rip_load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_exc   (resp_exc),
        .resp_cause (resp_cause),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_busy   (mem_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle counter: value seen mid-cycle is that cycle's index
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory channel model: busy for cur_k cycles starting the cycle after a strobe
    int   cur_k = 1;
    int   busy_cnt = 0;
    logic busy_r = 1'b0;
    logic force_busy = 1'b0;
    assign mem_busy = busy_r | force_busy;

    always @(posedge clk) begin
        if (rst) begin
            busy_r   <= 1'b0;
            busy_cnt <= 0;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) busy_r <= 1'b0;
        end else if (mem_re || (|mem_we)) begin
            busy_r   <= 1'b1;
            busy_cnt <= cur_k;
        end
    end

    // Scoreboard of expected responses
    typedef struct {
        logic [31:0] rdata;
        logic        exc;
        logic [3:0]  cause;
        int          cyc;
    } sb_item_t;
    sb_item_t sb[$];

    int          strobe_cnt = 0;
    int          resp_total = 0;
    logic [31:0] cap_addr, cap_din;
    logic [3:0]  cap_we;
    logic        cap_re;

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            resp_total++;
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_resp: got rdata %h with nothing expected (t=%0t)", resp_rdata, $time);
            end else begin
                sb_item_t it;
                it = sb.pop_front();
                check("resp_rdata", resp_rdata, it.rdata);
                check("resp_exc", {31'd0, resp_exc}, {31'd0, it.exc});
                check("resp_cause", {28'd0, resp_cause}, {28'd0, it.cause});
                if (it.cyc >= 0) check("resp_cycle", cyc, it.cyc);
            end
        end
        if (mem_re || (|mem_we)) begin
            strobe_cnt++;
            cap_addr = mem_addr;
            cap_din  = mem_din;
            cap_we   = mem_we;
            cap_re   = mem_re;
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] dout;
        int          k;
        logic        exc;
        logic [3:0]  cause;
        logic [3:0]  exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_din;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] dout, input int k,
                                input logic exc, input logic [3:0] cause, input logic [3:0] exp_we,
                                input logic [31:0] exp_addr, input logic [31:0] exp_din,
                                input logic [31:0] exp_rdata);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.dout = dout; v.k = k;
        v.exc = exc; v.cause = cause; v.exp_we = exp_we; v.exp_addr = exp_addr;
        v.exp_din = exp_din; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // Drive one request at the current (clock-low) time; it is accepted on the next edge.
    task automatic issue(input vec_t v, input bit expect_resp, input int lat);
        sb_item_t it;
        check("req_ready_at_issue", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        mem_dout   = v.dout;
        cur_k      = v.k;
        if (expect_resp) begin
            it.rdata = v.exp_rdata;
            it.exc   = v.exc;
            it.cause = v.cause;
            it.cyc   = (lat < 0) ? -1 : cyc + lat;
            sb.push_back(it);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got %0d responses outstanding expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    vec_t vecs[$];

    initial begin
        int s0;
        int r0;
        vec_t v1, v2;

        // Expected values derived by hand from the lane/extension rules.
        vecs.push_back(mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2, 0, 0, 4'b1111, 32'h100, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1, 0, 0, 4'b1000, 32'h100, 32'hA5A5A5A5, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'h102, 32'h0, 32'h0080FF00, 1, 0, 0, 4'b0000, 32'h100, 32'h0, 32'hFFFFFF80));
        vecs.push_back(mk(0, 3'b100, 32'h102, 32'h0, 32'h0080FF00, 3, 0, 0, 4'b0000, 32'h100, 32'h0, 32'h00000080));
        vecs.push_back(mk(0, 3'b001, 32'h102, 32'h0, 32'h80011234, 2, 0, 0, 4'b0000, 32'h100, 32'h0, 32'hFFFF8001));
        vecs.push_back(mk(0, 3'b101, 32'h102, 32'h0, 32'h80011234, 1, 0, 0, 4'b0000, 32'h100, 32'h0, 32'h00008001));
        vecs.push_back(mk(1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0, 2, 0, 0, 4'b1100, 32'h100, 32'hBEEFBEEF, 32'h0));
        vecs.push_back(mk(1, 3'b000, 32'h101, 32'h0000007F, 32'h0, 1, 0, 0, 4'b0010, 32'h100, 32'h7F7F7F7F, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 1, 0, 0, 4'b0000, 32'h100, 32'h0, 32'h0000007F));
        vecs.push_back(mk(0, 3'b001, 32'h100, 32'h0, 32'h0000F00F, 1, 0, 0, 4'b0000, 32'h100, 32'h0, 32'hFFFFF00F));
        vecs.push_back(mk(0, 3'b010, 32'h1FC, 32'h0, 32'h87654321, 4, 0, 0, 4'b0000, 32'h1FC, 32'h0, 32'h87654321));
`ifdef RIP_LSU_MISALIGN_CHECK_EN
        vecs.push_back(mk(0, 3'b010, 32'h101, 32'h0, 32'h11223344, 1, 1, 4'd4, 4'b0000, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 3'b001, 32'h103, 32'h5555AAAA, 32'h0, 1, 1, 4'd6, 4'b0000, 32'h0, 32'h0, 32'h0));
`else
        vecs.push_back(mk(0, 3'b010, 32'h101, 32'h0, 32'h11223344, 1, 0, 0, 4'b0000, 32'h100, 32'h0, 32'h11223344));
        vecs.push_back(mk(1, 3'b001, 32'h103, 32'h5555AAAA, 32'h0, 1, 0, 0, 4'b1100, 32'h100, 32'hAAAAAAAA, 32'h0));
`endif

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_dout = 32'h0;
        repeat (3) @(negedge clk);

        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_exc", {31'd0, resp_exc}, 32'd0);
        check("rst_resp_cause", {28'd0, resp_cause}, 32'd0);
        check("rst_mem_we", {28'd0, mem_we}, 32'd0);
        check("rst_mem_re", {31'd0, mem_re}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_din", mem_din, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven single transactions
        foreach (vecs[i]) begin
            s0 = strobe_cnt;
            issue(vecs[i], 1'b1, vecs[i].exc ? 1 : 3 + vecs[i].k);
            drain($sformatf("vec%0d", i));
            check($sformatf("vec%0d_strobes", i), strobe_cnt - s0, vecs[i].exc ? 0 : 1);
            if (!vecs[i].exc && strobe_cnt - s0 == 1) begin
                check($sformatf("vec%0d_mem_addr", i), cap_addr, vecs[i].exp_addr);
                check($sformatf("vec%0d_mem_we", i), {28'd0, cap_we}, {28'd0, vecs[i].exp_we});
                check($sformatf("vec%0d_mem_re", i), {31'd0, cap_re}, {31'd0, ~vecs[i].we});
                if (vecs[i].we) check($sformatf("vec%0d_mem_din", i), cap_din, vecs[i].exp_din);
            end
        end

        // Back-to-back: second request accepted in the resp_valid cycle
        v1 = mk(0, 3'b100, 32'h102, 32'h0, 32'h0080FF00, 1, 0, 0, 4'b0000, 32'h100, 32'h0, 32'h00000080);
        v2 = mk(1, 3'b010, 32'h104, 32'h01020304, 32'h0, 3, 0, 0, 4'b1111, 32'h104, 32'h01020304, 32'h0);
        s0 = strobe_cnt;
        issue(v1, 1'b1, 4);
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            #1;
            if (resp_valid) break;
        end
        check("b2b_resp_seen", {31'd0, resp_valid}, 32'd1);
        issue(v2, 1'b1, 6);
        drain("b2b");
        check("b2b_strobes", strobe_cnt - s0, 2);
        check("b2b_mem_addr", cap_addr, 32'h104);
        check("b2b_mem_we", {28'd0, cap_we}, 32'hF);
        check("b2b_mem_din", cap_din, 32'h01020304);

        // Memory busy while in ISSUE: no strobe until busy drops
        force_busy = 1'b1;
        s0 = strobe_cnt;
        v1 = mk(0, 3'b010, 32'h108, 32'h0, 32'hCAFEF00D, 2, 0, 0, 4'b0000, 32'h108, 32'h0, 32'hCAFEF00D);
        issue(v1, 1'b1, 7);
        @(negedge clk);
        check("busy_no_strobe", strobe_cnt - s0, 0);
        @(posedge clk);
        #1 force_busy = 1'b0;
        drain("busy_issue");
        check("busy_strobes", strobe_cnt - s0, 1);
        check("busy_mem_addr", cap_addr, 32'h108);

        // Reset during WAIT: the in-flight response is dropped
        s0 = strobe_cnt;
        r0 = resp_total;
        v1 = mk(0, 3'b010, 32'h200, 32'h0, 32'h12345678, 5, 0, 0, 4'b0000, 32'h200, 32'h0, 32'h12345678);
        issue(v1, 1'b0, -1);
        repeat (2) @(negedge clk);
        check("wait_mem_busy", {31'd0, mem_busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstw_req_ready", {31'd0, req_ready}, 32'd1);
        check("rstw_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rstw_mem_re", {31'd0, mem_re}, 32'd0);
        repeat (10) @(negedge clk);
        check("rstw_no_resp", resp_total - r0, 0);
        check("rstw_strobes", strobe_cnt - s0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
